// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory loader.
package imem_loader_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAY,
        CHK,
        DONE,
        ERROR
    } state_t;

    // Bytes per instruction word.
    function automatic int bpw(input int n);
        return n / BYTE_W;
    endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Packs a little-endian byte stream into N-bit words; word/word_valid are
// presented combinationally in the cycle the last byte of a word is accepted.
module imem_byte_packer
    import imem_loader_pkg::*;
#(
    parameter int N = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    output logic [N-1:0]      word,
    output logic              word_valid
);

    localparam int LANES = bpw(N);
    localparam int CW    = (LANES > 1) ? $clog2(LANES) : 1;

    logic [CW-1:0] cnt_reg;
    logic          last_lane;

    assign last_lane  = (cnt_reg == CW'(LANES - 1));
    assign word_valid = byte_valid && last_lane;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_reg <= '0;
        end else if (byte_valid) begin
            cnt_reg <= last_lane ? '0 : cnt_reg + CW'(1);
        end
    end

    // The top lane is never stored: it is the byte being accepted right now.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            if (gi < LANES - 1) begin : g_stored
                logic [BYTE_W-1:0] lane_reg;
                always_ff @(posedge clk) begin
                    if (reset || clear) begin
                        lane_reg <= '0;
                    end else if (byte_valid && (cnt_reg == CW'(gi))) begin
                        lane_reg <= byte_data;
                    end
                end
                assign word[gi*BYTE_W +: BYTE_W] = lane_reg;
            end else begin : g_live
                assign word[gi*BYTE_W +: BYTE_W] = byte_data;
            end
        end
    endgenerate

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader for a writable imem; holds the CPU while loading.
// Optional trailing checksum word enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int N     = 32,
    parameter int AW    = 7,
    parameter int DEPTH = 2**AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [N-1:0]      mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int LW = $clog2(DEPTH + 1);

    state_t        state_reg;
    logic [LW-1:0] len_reg;
    logic [LW-1:0] idx_reg;
    logic          mem_we_reg;
    logic [AW-1:0] mem_addr_reg;
    logic [N-1:0]  mem_wdata_reg;
    logic          cpu_hold_reg;
    logic          done_reg;
    logic          err_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [N-1:0]  sum_reg;
`endif

    logic          accept;
    logic          restart;
    logic [N-1:0]  word;
    logic          word_valid;
    logic          hdr_ok;
    logic          last_word;

    assign in_ready  = (state_reg == HDR) || (state_reg == PAY) || (state_reg == CHK);
    assign accept    = in_valid && in_ready;
    assign restart   = start && ((state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERROR));
    assign hdr_ok    = (word != '0) && (word <= N'(DEPTH));
    assign last_word = (idx_reg == len_reg - LW'(1));

    imem_byte_packer #(.N(N)) u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (restart),
        .byte_valid (accept),
        .byte_data  (in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            len_reg       <= '0;
            idx_reg       <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            cpu_hold_reg  <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_reg       <= '0;
`endif
        end else begin
            mem_we_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state_reg    <= HDR;
                        cpu_hold_reg <= 1'b1;
                        done_reg     <= 1'b0;
                        err_reg      <= 1'b0;
                        idx_reg      <= '0;
                        len_reg      <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_reg      <= '0;
`endif
                    end
                end
                HDR: begin
                    if (word_valid) begin
                        if (hdr_ok) begin
                            state_reg <= PAY;
                            len_reg   <= LW'(word);
                        end else begin
                            state_reg <= ERROR;
                            err_reg   <= 1'b1;
                        end
                    end
                end
                PAY: begin
                    if (word_valid) begin
                        mem_we_reg    <= 1'b1;
                        mem_addr_reg  <= AW'(idx_reg);
                        mem_wdata_reg <= word;
                        idx_reg       <= idx_reg + LW'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_reg       <= sum_reg + word;
                        if (last_word) begin
                            state_reg <= CHK;
                        end
`else
                        // Release the CPU on the same cycle as the final strobe.
                        if (last_word) begin
                            state_reg    <= DONE;
                            done_reg     <= 1'b1;
                            cpu_hold_reg <= 1'b0;
                        end
`endif
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: begin
                    if (word_valid) begin
                        if (word == sum_reg) begin
                            state_reg    <= DONE;
                            done_reg     <= 1'b1;
                            cpu_hold_reg <= 1'b0;
                        end else begin
                            state_reg <= ERROR;
                            err_reg   <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign cpu_hold  = cpu_hold_reg;
    assign done      = done_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte-stream model checked every cycle plus literal expectations.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int N     = 32;
    localparam int AW    = 7;
    localparam int BPW   = 4;
    localparam int DEPTH = 128;

    localparam int PH_IDLE = 0;
    localparam int PH_HDR  = 1;
    localparam int PH_PAY  = 2;
    localparam int PH_CHK  = 3;
    localparam int PH_DONE = 4;
    localparam int PH_ERR  = 5;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          start    = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data  = 8'h00;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [N-1:0]  mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          err;

    imem_loader #(.N(N), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs for the current cycle, derived from the accepted byte stream.
    int            m_phase = PH_IDLE;
    int            m_b     = 0;
    int            m_len   = 0;
    bit            m_ready = 0, m_we = 0, m_hold = 0, m_done = 0, m_err = 0;
    logic [AW-1:0] m_addr  = '0;
    logic [N-1:0]  m_data  = '0;
    logic [N-1:0]  m_word  = '0;
    logic [N-1:0]  m_sum   = '0;

    logic [AW-1:0] log_addr[$];
    logic [N-1:0]  log_data[$];

    always @(negedge clk) begin
        logic [N-1:0] w;
        int k;
        if (chk_en) begin
            cmp("in_ready",  in_ready,  m_ready);
            cmp("mem_we",    mem_we,    m_we);
            cmp("mem_addr",  mem_addr,  m_addr);
            cmp("mem_wdata", mem_wdata, m_data);
            cmp("cpu_hold",  cpu_hold,  m_hold);
            cmp("done",      done,      m_done);
            cmp("err",       err,       m_err);
            $display("cycle %0t: we=%0b addr=%0d data=%08h hold=%0b done=%0b err=%0b",
                     $time, mem_we, mem_addr, mem_wdata, cpu_hold, done, err);
        end
        if (mem_we === 1'b1) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
        end
        m_we = 1'b0;
        if (reset) begin
            m_phase = PH_IDLE; m_ready = 0; m_hold = 0; m_done = 0; m_err = 0;
            m_addr = '0; m_data = '0; m_b = 0; m_word = '0; m_sum = '0; m_len = 0;
        end else if (start && (m_phase == PH_IDLE || m_phase == PH_DONE || m_phase == PH_ERR)) begin
            m_phase = PH_HDR; m_ready = 1; m_hold = 1; m_done = 0; m_err = 0;
            m_b = 0; m_word = '0; m_sum = '0;
        end else if (in_valid && m_ready) begin
            m_word = m_word | (N'(in_data) << (8 * (m_b % BPW)));
            m_b++;
            if (m_b % BPW == 0) begin
                w = m_word;
                m_word = '0;
                k = m_b / BPW - 1;
                if (m_phase == PH_HDR) begin
                    if (w == 0 || w > N'(DEPTH)) begin
                        m_phase = PH_ERR; m_err = 1; m_ready = 0;
                    end else begin
                        m_phase = PH_PAY; m_len = int'(w);
                    end
                end else if (m_phase == PH_PAY) begin
                    m_we = 1; m_addr = AW'(k - 1); m_data = w; m_sum = m_sum + w;
                    if (k == m_len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        m_phase = PH_CHK;
`else
                        m_phase = PH_DONE; m_ready = 0; m_hold = 0; m_done = 1;
`endif
                    end
                end else if (m_phase == PH_CHK) begin
                    m_ready = 0;
                    if (w == m_sum) begin
                        m_phase = PH_DONE; m_hold = 0; m_done = 1;
                    end else begin
                        m_phase = PH_ERR; m_err = 1;
                    end
                end
            end
        end
    end

    logic [7:0] stim_q[$];

    task automatic push_word(input logic [31:0] w);
        for (int j = 0; j < BPW; j++) stim_q.push_back(w[8*j +: 8]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send(input bit toggle);
        int i = 0;
        int guard = 0;
        bit ph = 1'b1;
        bit hs;
        while (i < stim_q.size() && guard < 500) begin
            in_valid = toggle ? ph : 1'b1;
            in_data  = stim_q[i];
            hs = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (hs) i++;
            ph = !ph;
            guard++;
        end
        in_valid = 1'b0;
        if (i < stim_q.size()) cmp("send_timeout", 64'(i), 64'(stim_q.size()));
        stim_q.delete();
    endtask

    task automatic load_two_words();
        push_word(32'd2);
        push_word(32'hf8000001);
        push_word(32'hf8008002);
`ifdef IMEM_LOADER_CHECKSUM_EN
        push_word(32'hf0008003);
`endif
    endtask

    int n0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;

        // 1: idle after reset, random traffic must not be accepted
        cmp("rst_in_ready", in_ready, 1'b0);
        cmp("rst_cpu_hold", cpu_hold, 1'b0);
        cmp("rst_done", done, 1'b0);
        cmp("rst_err", err, 1'b0);
        cmp("rst_mem_addr", mem_addr, 0);
        for (int c = 0; c < 12; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            idle(1);
        end
        in_valid = 1'b0;
        cmp("idle_writes", 64'(log_data.size()), 0);

        // 2: two-word image, back-to-back bytes
        pulse_start();
        cmp("start_hold", cpu_hold, 1'b1);
        n0 = log_data.size();
        load_two_words();
        send(1'b0);
        idle(2);
        cmp("t2_nwrites", 64'(log_data.size() - n0), 2);
        cmp("t2_addr0", log_addr[n0], 0);
        cmp("t2_data0", log_data[n0], 32'hf8000001);
        cmp("t2_addr1", log_addr[n0+1], 1);
        cmp("t2_data1", log_data[n0+1], 32'hf8008002);
        cmp("t2_done", done, 1'b1);
        cmp("t2_hold", cpu_hold, 1'b0);

        // 3: bad headers
        pulse_start();
        cmp("t3_done_clr", done, 1'b0);
        n0 = log_data.size();
        push_word(32'h00000000);
        send(1'b0);
        idle(2);
        cmp("t3_err_zero", err, 1'b1);
        cmp("t3_hold_zero", cpu_hold, 1'b1);
        pulse_start();
        cmp("t3_err_clr", err, 1'b0);
        push_word(32'h00000081);
        send(1'b0);
        idle(2);
        cmp("t3_err_big", err, 1'b1);
        cmp("t3_hold_big", cpu_hold, 1'b1);
        cmp("t3_nwrites", 64'(log_data.size() - n0), 0);

        // 4: same image with in_valid toggling
        pulse_start();
        cmp("t4_err_clr", err, 1'b0);
        n0 = log_data.size();
        load_two_words();
        send(1'b1);
        idle(2);
        cmp("t4_nwrites", 64'(log_data.size() - n0), 2);
        cmp("t4_data0", log_data[n0], 32'hf8000001);
        cmp("t4_data1", log_data[n0+1], 32'hf8008002);
        cmp("t4_addr1", log_addr[n0+1], 1);
        cmp("t4_done", done, 1'b1);

        // 5: reset after 1.5 words of a 4-word image
        pulse_start();
        n0 = log_data.size();
        push_word(32'd4);
        push_word(32'h11223344);
        stim_q.push_back(8'h55);
        stim_q.push_back(8'h66);
        send(1'b0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        cmp("t5_hold", cpu_hold, 1'b0);
        cmp("t5_ready", in_ready, 1'b0);
        cmp("t5_addr", mem_addr, 0);
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            idle(1);
        end
        in_valid = 1'b0;
        cmp("t5_nwrites", 64'(log_data.size() - n0), 1);
        cmp("t5_data0", log_data[n0], 32'h11223344);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // 6: checksum mismatch after both payload writes
        pulse_start();
        n0 = log_data.size();
        push_word(32'd2);
        push_word(32'hf8000001);
        push_word(32'hf8008002);
        push_word(32'hf0008004);
        send(1'b0);
        idle(2);
        cmp("t6_err", err, 1'b1);
        cmp("t6_hold", cpu_hold, 1'b1);
        cmp("t6_nwrites", 64'(log_data.size() - n0), 2);
`endif

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
